// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder and its controller:
// mnemonic codes, MIPS32 opcode/funct fields, FSM states and the encoder.
package instr_encoder_pkg;

   typedef enum logic [5:0] {
      M_ADD = 6'd0, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR,
      M_XOR, M_NOR, M_SLT, M_SLTU,
      M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV,
      M_ROTR, M_ROTRV,
      M_ADDI, M_ADDIU, M_SLTI, M_SLTIU,
      M_ANDI, M_ORI, M_XORI, M_LUI,
      M_CLZ, M_CLO, M_SEB, M_SEH,
      M_BLTZ, M_BGEZ, M_BEQ, M_BNE, M_BLEZ, M_BGTZ,
      M_J, M_JAL
   } mnem_e;

   typedef enum logic [1:0] {
      S_IDLE, S_LOAD, S_DRAIN, S_DONE
   } state_e;

   localparam logic [5:0] OP_SPECIAL  = 6'b000000;
   localparam logic [5:0] OP_REGIMM   = 6'b000001;
   localparam logic [5:0] OP_J        = 6'b000010;
   localparam logic [5:0] OP_JAL      = 6'b000011;
   localparam logic [5:0] OP_BEQ      = 6'b000100;
   localparam logic [5:0] OP_BNE      = 6'b000101;
   localparam logic [5:0] OP_BLEZ     = 6'b000110;
   localparam logic [5:0] OP_BGTZ     = 6'b000111;
   localparam logic [5:0] OP_ADDI     = 6'b001000;
   localparam logic [5:0] OP_ADDIU    = 6'b001001;
   localparam logic [5:0] OP_SLTI     = 6'b001010;
   localparam logic [5:0] OP_SLTIU    = 6'b001011;
   localparam logic [5:0] OP_ANDI     = 6'b001100;
   localparam logic [5:0] OP_ORI      = 6'b001101;
   localparam logic [5:0] OP_XORI     = 6'b001110;
   localparam logic [5:0] OP_LUI      = 6'b001111;
   localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
   localparam logic [5:0] OP_SPECIAL3 = 6'b011111;

   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_SRA   = 6'b000011;
   localparam logic [5:0] FN_SLLV  = 6'b000100;
   localparam logic [5:0] FN_SRLV  = 6'b000110;
   localparam logic [5:0] FN_SRAV  = 6'b000111;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_XOR   = 6'b100110;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLTU  = 6'b101011;
   localparam logic [5:0] FN_CLZ   = 6'b100000;
   localparam logic [5:0] FN_CLO   = 6'b100001;
   localparam logic [5:0] FN_BSHFL = 6'b100000;

   localparam logic [4:0] SA_SEB   = 5'b10000;
   localparam logic [4:0] SA_SEH   = 5'b10001;
   localparam logic [4:0] RT_BLTZ  = 5'b00000;
   localparam logic [4:0] RT_BGEZ  = 5'b00001;
   localparam logic [4:0] ROT_BIT  = 5'b00001;

   typedef struct packed {
      logic        ok;
      logic [31:0] word;
   } enc_t;

   function automatic logic [31:0] r_fmt(
      input logic [5:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd,
      input logic [4:0] sa, input logic [5:0] fn);
      return {op, rs, rt, rd, sa, fn};
   endfunction

   function automatic logic [31:0] i_fmt(
      input logic [5:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic enc_t encode(
      input logic [5:0]  code,
      input logic [4:0]  rs, input logic [4:0] rt,
      input logic [4:0]  rd, input logic [4:0] sa,
      input logic [15:0] imm, input logic [25:0] tgt);
      enc_t e;
      e.ok   = 1'b1;
      e.word = '0;
      unique case (mnem_e'(code))
         M_ADD:   e.word = r_fmt(OP_SPECIAL, rs, rt, rd, 5'd0, FN_ADD);
         M_ADDU:  e.word = r_fmt(OP_SPECIAL, rs, rt, rd, 5'd0, FN_ADDU);
         M_SUB:   e.word = r_fmt(OP_SPECIAL, rs, rt, rd, 5'd0, FN_SUB);
         M_SUBU:  e.word = r_fmt(OP_SPECIAL, rs, rt, rd, 5'd0, FN_SUBU);
         M_AND:   e.word = r_fmt(OP_SPECIAL, rs, rt, rd, 5'd0, FN_AND);
         M_OR:    e.word = r_fmt(OP_SPECIAL, rs, rt, rd, 5'd0, FN_OR);
         M_XOR:   e.word = r_fmt(OP_SPECIAL, rs, rt, rd, 5'd0, FN_XOR);
         M_NOR:   e.word = r_fmt(OP_SPECIAL, rs, rt, rd, 5'd0, FN_NOR);
         M_SLT:   e.word = r_fmt(OP_SPECIAL, rs, rt, rd, 5'd0, FN_SLT);
         M_SLTU:  e.word = r_fmt(OP_SPECIAL, rs, rt, rd, 5'd0, FN_SLTU);
         M_SLL:   e.word = r_fmt(OP_SPECIAL, 5'd0, rt, rd, sa, FN_SLL);
         M_SRL:   e.word = r_fmt(OP_SPECIAL, 5'd0, rt, rd, sa, FN_SRL);
         M_SRA:   e.word = r_fmt(OP_SPECIAL, 5'd0, rt, rd, sa, FN_SRA);
         M_SLLV:  e.word = r_fmt(OP_SPECIAL, rs, rt, rd, 5'd0, FN_SLLV);
         M_SRLV:  e.word = r_fmt(OP_SPECIAL, rs, rt, rd, 5'd0, FN_SRLV);
         M_SRAV:  e.word = r_fmt(OP_SPECIAL, rs, rt, rd, 5'd0, FN_SRAV);
         // rotates reuse the logical right shifts with the R bit set
         M_ROTR:  e.word = r_fmt(OP_SPECIAL, ROT_BIT, rt, rd, sa, FN_SRL);
         M_ROTRV: e.word = r_fmt(OP_SPECIAL, rs, rt, rd, ROT_BIT, FN_SRLV);
         M_ADDI:  e.word = i_fmt(OP_ADDI, rs, rt, imm);
         M_ADDIU: e.word = i_fmt(OP_ADDIU, rs, rt, imm);
         M_SLTI:  e.word = i_fmt(OP_SLTI, rs, rt, imm);
         M_SLTIU: e.word = i_fmt(OP_SLTIU, rs, rt, imm);
         M_ANDI:  e.word = i_fmt(OP_ANDI, rs, rt, imm);
         M_ORI:   e.word = i_fmt(OP_ORI, rs, rt, imm);
         M_XORI:  e.word = i_fmt(OP_XORI, rs, rt, imm);
         M_LUI:   e.word = i_fmt(OP_LUI, 5'd0, rt, imm);
         M_CLZ:   e.word = r_fmt(OP_SPECIAL2, rs, rd, rd, 5'd0, FN_CLZ);
         M_CLO:   e.word = r_fmt(OP_SPECIAL2, rs, rd, rd, 5'd0, FN_CLO);
         M_SEB:   e.word = r_fmt(OP_SPECIAL3, 5'd0, rt, rd, SA_SEB, FN_BSHFL);
         M_SEH:   e.word = r_fmt(OP_SPECIAL3, 5'd0, rt, rd, SA_SEH, FN_BSHFL);
         M_BLTZ:  e.word = i_fmt(OP_REGIMM, rs, RT_BLTZ, imm);
         M_BGEZ:  e.word = i_fmt(OP_REGIMM, rs, RT_BGEZ, imm);
         M_BEQ:   e.word = i_fmt(OP_BEQ, rs, rt, imm);
         M_BNE:   e.word = i_fmt(OP_BNE, rs, rt, imm);
         M_BLEZ:  e.word = i_fmt(OP_BLEZ, rs, 5'd0, imm);
         M_BGTZ:  e.word = i_fmt(OP_BGTZ, rs, 5'd0, imm);
         M_J:     e.word = {OP_J, tgt};
         M_JAL:   e.word = {OP_JAL, tgt};
         default: e.ok   = 1'b0;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Synchronous FIFO buffering encoded words ahead of the memory port.
// Pointers carry one extra wrap bit to tell full from empty.
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_q, wr_d;
   logic [AW:0]  rd_q, rd_d;
   logic         do_push;
   logic         do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                    (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/instr_encoder.sv
// Encodes field requests into MIPS32 words and streams them into
// instruction memory from base_addr through a small output buffer.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ADDR_W     = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [5:0]        in_mnem,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] count
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              err_q, err_d;

   enc_t              enc;
   logic              accept;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic [31:0]       head;

   assign enc = encode(in_mnem, in_rs, in_rt, in_rd,
                       in_shamt, in_imm, in_target);

   assign in_ready = (state_q == S_LOAD) && !full;
   assign accept   = in_valid && in_ready;
   assign push     = accept && enc.ok;
   assign pop      = mem_we && mem_ready;

   instr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (32)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .din_i   (enc.word),
      .pop_i   (pop),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   // stale storage is hidden while the buffer is empty
   assign mem_we    = !empty;
   assign mem_wdata = empty ? '0 : head;
   assign mem_addr  = wptr_q;
   assign busy      = (state_q == S_LOAD) || (state_q == S_DRAIN);
   assign done      = (state_q == S_DONE);
   assign err       = err_q;
   assign count     = cnt_q;

   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      if (pop) begin
         wptr_d = wptr_q + ADDR_W'(4);
         cnt_d  = cnt_q + 1'b1;
      end
      if (accept && !enc.ok) err_d = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               wptr_d  = base_addr;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         S_LOAD:  if (accept && in_last) state_d = S_DRAIN;
         S_DRAIN: if (empty) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         wptr_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table plus
// back-pressure, error, address-wrap and mid-session reset sequences.
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic [11:0] base_addr;
   logic        in_valid;
   logic        in_ready;
   logic        in_last;
   logic [5:0]  in_mnem;
   logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic        busy, done, err;
   logic [11:0] count;

   instr_encoder #(.ADDR_W(12), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_last   (in_last),
      .in_mnem   (in_mnem),
      .in_rs     (in_rs),
      .in_rt     (in_rt),
      .in_rd     (in_rd),
      .in_shamt  (in_shamt),
      .in_imm    (in_imm),
      .in_target (in_target),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .count     (count)
   );

   typedef struct {
      logic [5:0]  mnem;
      logic [4:0]  rs, rt, rd, sa;
      logic [15:0] imm;
      logic [25:0] tgt;
      logic [31:0] exp;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   logic [11:0] wa[$];
   logic [31:0] wd[$];
   vec_t        vt[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_we && mem_ready) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
         end
         if (done) done_cnt++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input mnem_e m, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sa,
      input logic [15:0] imm, input logic [25:0] tgt,
      input logic [31:0] exp);
      vec_t v;
      v.mnem = m; v.rs = rs; v.rt = rt; v.rd = rd; v.sa = sa;
      v.imm = imm; v.tgt = tgt; v.exp = exp;
      return v;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_session(input logic [11:0] b);
      start = 1'b1;
      base_addr = b;
      cyc();
      start = 1'b0;
   endtask

   task automatic drive(input vec_t v, input logic last);
      in_valid = 1'b1;  in_last = last;
      in_mnem = v.mnem; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
      in_shamt = v.sa;  in_imm = v.imm; in_target = v.tgt;
   endtask

   task automatic send(input vec_t v, input logic last);
      int k = 0;
      drive(v, last);
      @(negedge clk);
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) chk("send timeout", {31'd0, in_ready}, 32'd1);
      cyc();
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic wait_done();
      int k = 0;
      @(negedge clk);
      while (!done && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!done) chk("done timeout", {31'd0, done}, 32'd1);
      cyc();
   endtask

   initial begin
      int d0;
      vec_t bad;
      rst = 1'b1; start = 1'b0; base_addr = '0;
      in_valid = 1'b0; in_last = 1'b0; in_mnem = '0;
      in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
      in_imm = '0; in_target = '0; mem_ready = 1'b1;

      vt.push_back(mk(M_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'd0, 32'h2022FFFF));
      vt.push_back(mk(M_BGEZ, 5'd3, 5'd0, 5'd0, 5'd0, 16'h0004, 26'd0, 32'h04610004));
      vt.push_back(mk(M_BLTZ, 5'd3, 5'd7, 5'd0, 5'd0, 16'h0004, 26'd0, 32'h04600004));
      vt.push_back(mk(M_ROTR, 5'd9, 5'd5, 5'd4, 5'd3, 16'h0, 26'd0, 32'h002520C2));
      vt.push_back(mk(M_ADD, 5'd1, 5'd2, 5'd3, 5'd5, 16'h0, 26'd0, 32'h00221820));
      vt.push_back(mk(M_SLTU, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'd0, 32'h0022182B));
      vt.push_back(mk(M_SLL, 5'd7, 5'd5, 5'd4, 5'd3, 16'h0, 26'd0, 32'h000520C0));
      vt.push_back(mk(M_SRAV, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'd0, 32'h00221807));
      vt.push_back(mk(M_ROTRV, 5'd6, 5'd5, 5'd4, 5'd9, 16'h0, 26'd0, 32'h00C52046));
      vt.push_back(mk(M_XORI, 5'd1, 5'd2, 5'd0, 5'd0, 16'h00FF, 26'd0, 32'h382200FF));
      vt.push_back(mk(M_LUI, 5'd9, 5'd7, 5'd0, 5'd0, 16'h1234, 26'd0, 32'h3C071234));
      vt.push_back(mk(M_CLZ, 5'd2, 5'd9, 5'd3, 5'd0, 16'h0, 26'd0, 32'h70431820));
      vt.push_back(mk(M_CLO, 5'd2, 5'd9, 5'd3, 5'd0, 16'h0, 26'd0, 32'h70431821));
      vt.push_back(mk(M_SEB, 5'd1, 5'd5, 5'd6, 5'd0, 16'h0, 26'd0, 32'h7C053420));
      vt.push_back(mk(M_SEH, 5'd1, 5'd5, 5'd6, 5'd0, 16'h0, 26'd0, 32'h7C053460));
      vt.push_back(mk(M_BLEZ, 5'd4, 5'd9, 5'd0, 5'd0, 16'hFFFE, 26'd0, 32'h1880FFFE));
      vt.push_back(mk(M_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0008, 26'd0, 32'h10220008));
      vt.push_back(mk(M_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0123456, 32'h08123456));
      vt.push_back(mk(M_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF, 32'h0FFFFFFF));

      repeat (2) cyc();
      chk("reset in_ready", {31'd0, in_ready}, 32'd0);
      chk("reset mem_we", {31'd0, mem_we}, 32'd0);
      chk("reset busy/done/err", {29'd0, busy, done, err}, 32'd0);
      chk("reset count", {20'd0, count}, 32'd0);
      rst = 1'b0;
      cyc();

      // single-request sessions from the encoding table
      for (int i = 0; i < vt.size(); i++) begin
         wa.delete(); wd.delete();
         d0 = done_cnt;
         begin_session(12'h000);
         send(vt[i], 1'b1);
         wait_done();
         cyc();
         chk($sformatf("vec%0d writes", i), wa.size(), 32'd1);
         if (wa.size() > 0) begin
            chk($sformatf("vec%0d word", i), wd[0], vt[i].exp);
            chk($sformatf("vec%0d addr", i), {20'd0, wa[0]}, 32'd0);
         end
         chk($sformatf("vec%0d count", i), {20'd0, count}, 32'd1);
         chk($sformatf("vec%0d done pulses", i), done_cnt - d0, 32'd1);
         chk($sformatf("vec%0d idle", i), {30'd0, busy, err}, 32'd0);
      end

      // back-pressure: buffer fills after four accepts
      wa.delete(); wd.delete();
      mem_ready = 1'b0;
      begin_session(12'h000);
      for (int k = 0; k < 4; k++)
         send(mk(M_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 16'(k), 26'd0, 32'h0), 1'b0);
      drive(mk(M_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 16'd4, 26'd0, 32'h0), 1'b1);
      @(negedge clk);
      chk("bp in_ready full", {31'd0, in_ready}, 32'd0);
      chk("bp mem_we", {31'd0, mem_we}, 32'd1);
      cyc();
      @(negedge clk);
      chk("bp in_ready held", {31'd0, in_ready}, 32'd0);
      chk("bp no early writes", wa.size(), 32'd0);
      cyc();
      mem_ready = 1'b1;
      send(mk(M_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 16'd4, 26'd0, 32'h0), 1'b1);
      wait_done();
      chk("bp writes", wa.size(), 32'd5);
      for (int k = 0; k < 5; k++)
         if (wa.size() > k) begin
            chk($sformatf("bp addr%0d", k), {20'd0, wa[k]}, 32'(4 * k));
            chk($sformatf("bp word%0d", k), wd[k], 32'h20220000 + 32'(k));
         end
      chk("bp count", {20'd0, count}, 32'd5);

      // undefined mnemonic: sticky err, nothing written for it
      wa.delete(); wd.delete();
      bad = mk(M_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'd0, 32'h0);
      bad.mnem = 6'h3F;
      begin_session(12'h000);
      send(mk(M_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0055, 26'd0, 32'h0), 1'b0);
      send(bad, 1'b1);
      @(negedge clk);
      chk("err set", {31'd0, err}, 32'd1);
      wait_done();
      repeat (3) cyc();
      chk("err sticky", {31'd0, err}, 32'd1);
      chk("err writes", wa.size(), 32'd1);
      if (wa.size() > 0) chk("err word", wd[0], 32'h20220055);
      chk("err count", {20'd0, count}, 32'd1);
      begin_session(12'h000);
      chk("err cleared by start", {31'd0, err}, 32'd0);
      send(vt[0], 1'b1);
      wait_done();

      // address wrap at top of memory
      wa.delete(); wd.delete();
      begin_session(12'hFFC);
      send(vt[1], 1'b0);
      send(vt[2], 1'b1);
      wait_done();
      chk("wrap writes", wa.size(), 32'd2);
      if (wa.size() > 1) begin
         chk("wrap addr0", {20'd0, wa[0]}, 32'h00000FFC);
         chk("wrap addr1", {20'd0, wa[1]}, 32'h00000000);
         chk("wrap word1", wd[1], 32'h04600004);
      end
      chk("wrap count", {20'd0, count}, 32'd2);

      // reset with three words buffered
      mem_ready = 1'b0;
      begin_session(12'h100);
      for (int k = 0; k < 3; k++) send(vt[k], 1'b0);
      chk("pre-rst mem_we", {31'd0, mem_we}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst mem_addr", {20'd0, mem_addr}, 32'd0);
      chk("rst mem_wdata", mem_wdata, 32'd0);
      chk("rst flags", {28'd0, in_ready, busy, done, err}, 32'd0);
      wa.delete(); wd.delete();
      repeat (2) cyc();
      rst = 1'b0;
      mem_ready = 1'b1;
      repeat (10) cyc();
      chk("post-rst writes", wa.size(), 32'd0);
      chk("post-rst busy", {31'd0, busy}, 32'd0);
      chk("post-rst count", {20'd0, count}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, byte-address width of the instruction-memory write port.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of output buffer entries, power of two.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  in  1  begin a load session at base_addr; ignored unless IDLE.
REQ-006 SHALL have port base_addr  in  ADDR_W  first write address, sampled with start.
REQ-007 SHALL have ports in_valid (in, 1), in_ready (out, 1), in_last (in, 1): field-request handshake; in_last marks the final request of the session.
REQ-008 SHALL have port in_mnem  in  6  mnemonic code from the shared package.
REQ-009 SHALL have ports in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
REQ-010 SHALL have ports in_imm (in, 16) and in_target (in, 26): immediate/branch offset and jump target.
REQ-011 SHALL have ports mem_we (out, 1), mem_addr (out, ADDR_W), mem_wdata (out, 32), mem_ready (in, 1): write completes on a cycle with mem_we and mem_ready both high.
REQ-012 SHALL have ports busy (out, 1), done (out, 1), err (out, 1), count (out, ADDR_W).

Function
REQ-013 SHALL use FSM states IDLE, LOAD, DRAIN, DONE: IDLE->LOAD on start; LOAD->DRAIN on accepted in_last; DRAIN->DONE when FIFO is empty and no write is pending; DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL drive in_ready = (state==LOAD) and FIFO not full; a pop in the same cycle SHALL NOT enable a push while full.
REQ-015 SHALL encode an accepted request combinationally and push the word into the FIFO at the accepting edge, so mem_we is first visible on the next cycle.
REQ-016 SHALL encode R-type ALU ops (ADD..SLTU, per MIPS32 funct values) as op 000000 with rs/rt/rd and sa=0.
REQ-017 SHALL encode SLL/SRA/SRL as op 000000, rs=0, sa=in_shamt; SLLV/SRAV/SRLV as op 000000, sa=0; ROTR as the SRL encoding with rs=00001; ROTRV as the SRLV encoding with sa=00001.
REQ-018 SHALL encode ADDI..XORI as op 001000..001110, LUI as op 001111 with rs=0, rt as the destination, imm=in_imm.
REQ-019 SHALL encode CLZ/CLO as op 011100, funct 100000/100001, rt=rd=in_rd; SEB/SEH as op 011111, rs=0, funct 100000, sa=10000/10001.
REQ-020 SHALL encode BLTZ/BGEZ as op 000001 with rt=00000/00001; BEQ, BNE, BLEZ, BGTZ as op 000100..000111, with rt forced to 0 for BLEZ/BGTZ.
REQ-021 SHALL encode J/JAL as op 000010/000011 with in_target.
REQ-022 SHALL set err for an undefined in_mnem, keep it set until the next start or reset, push nothing, and still honour in_last.
REQ-023 SHALL drive mem_we = FIFO not empty, mem_wdata = FIFO head, and mem_addr = write pointer; the pointer loads base_addr on start and advances by 4 per completed write, wrapping modulo 2^ADDR_W.
REQ-024 SHALL increment count per completed write; count clears on start.
REQ-025 SHALL drive busy high in LOAD and DRAIN, and done high for exactly the DONE cycle.

Reset
REQ-026 SHALL, on rst at any time including mid-session, immediately force: IDLE, FIFO emptied, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, count=0.

Structure
REQ-027 SHALL take the mnemonic enumeration, opcode and funct constants, and FSM state encoding from a shared package used with the controller.
REQ-028 SHALL implement the output buffer as sub-module instr_fifo, a synchronous FIFO with full/empty flags.

Verification
REQ-029 SHALL check: base=0x000, ADDI rs=1 rt=2 imm=0xFFFF, last -> one write 0x2022FFFF @0x000, done pulse, count=1.
REQ-030 SHALL check: BGEZ rs=3 imm=4 -> 0x04610004; BLTZ rs=3 imm=4 -> 0x04600004; ROTR rd=4 rt=5 shamt=3 -> 0x002520C2.
REQ-031 SHALL check: mem_ready=0 for 6 cycles while 5 requests are offered -> in_ready drops after 4 accepts, then writes go to 0x000, 0x004, 0x008, 0x00C, 0x010 in order with none lost.
REQ-032 SHALL check: in_mnem=0x3F -> err=1 sticky, no write, count unchanged; the next start clears err.
REQ-033 SHALL check: base=0xFFC, two requests -> writes at 0xFFC then 0x000.
REQ-034 SHALL check: rst asserted with 3 words buffered -> mem_we=0 immediately, and no writes occur after rst is released.
